// File: rtl/hs_bridge_pkg.sv
// Shared types for the req/ack <-> valid/ready bridge pair.
// Holds the receive and transmit state encodings and the count-width helper.
package hs_bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_DROP = 2'd2
    } hs_rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_REQ  = 2'd1,
        T_WAIT = 2'd2
    } hs_tx_state_t;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hs_rx_fifo.sv
// Receive buffer: memory, pointers, word count and registered stream output.
// count covers the memory plus the output register.
module hs_rx_fifo
    import hs_bridge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             full,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             mem_empty, load, pop;

    always_comb begin
        // Words in memory are the total minus the one held in the output register.
        mem_empty = (count_q == CNT_W'(valid_q));
        pop       = valid_q && rd_ready;
        load      = (!valid_q || rd_ready) && !mem_empty;
        wr_ptr_d  = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = load ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        data_d    = load ? mem_q[rd_ptr_q] : data_q;
        valid_d   = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign full     = (count_q == CNT_W'(DEPTH));
    assign data_out = data_q;
    assign valid    = valid_q;
    assign count    = count_q;

endmodule

// File: rtl/hs_rx_bridge.sv
// 4-phase req/ack receiver feeding a buffered valid/ready stream.
// Define HS_RX_SYNC_EN to pass req through a SYNC_STAGES flop synchronizer.
module hs_rx_bridge
    import hs_bridge_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          data_in,
    input  logic                      req,
    output logic                      ack,
    output logic [WIDTH-1:0]          data_out,
    output logic                      valid,
    input  logic                      ready,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    hs_rx_state_t state_q;
    logic         ack_q;
    logic         req_s;
    logic         sync_ok;
    logic         full;
    logic         wr_en;

`ifdef HS_RX_SYNC_EN
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] prime_q;

    // prime_q marks when sync_q holds real samples, so a req live
    // across reset is not mistaken for a low level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            prime_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], req};
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign req_s   = sync_q[SYNC_STAGES-1];
    assign sync_ok = prime_q[SYNC_STAGES-1];
`else
    assign req_s   = req;
    assign sync_ok = 1'b1;
`endif

    assign wr_en = (state_q == R_IDLE) && req_s && !full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= R_DROP;
            ack_q   <= 1'b0;
        end else begin
            unique case (state_q)
                R_IDLE: begin
                    if (wr_en) begin
                        state_q <= R_ACK;
                        ack_q   <= 1'b1;
                    end
                end
                R_ACK: begin
                    if (!req_s) begin
                        state_q <= R_IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                R_DROP: begin
                    ack_q <= 1'b0;
                    if (!req_s && sync_ok) begin
                        state_q <= R_IDLE;
                    end
                end
                default: begin
                    state_q <= R_DROP;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ack = ack_q;

    hs_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (data_in),
        .rd_ready (ready),
        .full     (full),
        .data_out (data_out),
        .valid    (valid),
        .count    (count)
    );

endmodule
